// File: rtl/mcpu_gen2_if.sv
// mcpu_gen2 memory port: req/ack handshake with address and
// data held stable until ack. master = core, slave = memory.
interface mcpu_gen2_if #(
  parameter int ADDR_W  = 8,
  parameter int INSTR_W = 16
) ();
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [INSTR_W-1:0] mem_wdata;
  logic               mem_ack;
  logic [INSTR_W-1:0] mem_rdata;

  modport master (
    output mem_req,
    output mem_we,
    output mem_addr,
    output mem_wdata,
    input  mem_ack,
    input  mem_rdata
  );

  modport slave (
    input  mem_req,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata,
    output mem_ack,
    output mem_rdata
  );
endinterface

// File: rtl/mcpu_gen2.sv
// mcpu_gen2: parametrised multi-cycle core with external req/ack memory.
// Branches (JMP/BEQZ) exist only when MCPU_GEN2_BRANCH_EN is defined.
module mcpu_gen2 #(
  parameter int DATA_W = 8,
  parameter int REG_AW = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  mcpu_gen2_if.master       mem,
  output logic              halted,
  output logic [ADDR_W-1:0] pc,
  input  logic [REG_AW-1:0] dbg_raddr,
  output logic [DATA_W-1:0] dbg_rdata
);
  localparam int INSTR_W = 4 + REG_AW + ADDR_W;
  localparam int NREG    = 2 ** REG_AW;

  localparam logic [3:0] OP_LI    = 4'd0;
  localparam logic [3:0] OP_MOV   = 4'd1;
  localparam logic [3:0] OP_ADD   = 4'd2;
  localparam logic [3:0] OP_SUB   = 4'd3;
  localparam logic [3:0] OP_XOR   = 4'd4;
  localparam logic [3:0] OP_OR    = 4'd5;
  localparam logic [3:0] OP_AND   = 4'd6;
  localparam logic [3:0] OP_STORE = 4'd7;
  localparam logic [3:0] OP_LOAD  = 4'd8;
  localparam logic [3:0] OP_HALT  = 4'd15;
`ifdef MCPU_GEN2_BRANCH_EN
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_BEQZ  = 4'd10;
`endif

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_t;

  state_t state;
  state_t state_nx;

  logic [INSTR_W-1:0] ir;
  logic [DATA_W-1:0]  rf [NREG];

  logic [3:0]        op;
  logic [REG_AW-1:0] rd;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [ADDR_W-1:0] f;
  logic [DATA_W-1:0] imm;
  logic [DATA_W-1:0] rd_v;
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;

  logic              wr_en;
  logic [DATA_W-1:0] wr_val;
  logic              fetch_done;

  assign op  = ir[INSTR_W-1 -: 4];
  assign rd  = ir[INSTR_W-5 -: REG_AW];
  assign f   = ir[ADDR_W-1:0];
  assign rs  = f[ADDR_W-1 -: REG_AW];
  assign rt  = f[ADDR_W-1-REG_AW -: REG_AW];
  assign imm = DATA_W'(f);

  assign rd_v = rf[rd];
  assign a    = rf[rs];
  assign b    = rf[rt];

  assign dbg_rdata = rf[dbg_raddr];
  assign halted    = (state == S_HALT);

  assign fetch_done = (state == S_FETCH) && mem.mem_ack;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= S_FETCH;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_FETCH: begin
        if (mem.mem_ack) state_nx = S_EXEC;
      end
      S_EXEC: begin
        case (op)
          OP_STORE, OP_LOAD: state_nx = S_MEM;
          OP_HALT:           state_nx = S_HALT;
          default:           state_nx = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem.mem_ack) state_nx = S_FETCH;
      end
      S_HALT: begin
        state_nx = S_HALT;
      end
    endcase
  end

  // Bus outputs are pure functions of state, so they hold until ack.
  always_comb begin
    mem.mem_req   = 1'b0;
    mem.mem_we    = 1'b0;
    mem.mem_addr  = '0;
    mem.mem_wdata = '0;
    if (reset) begin
      unique case (state)
        S_FETCH: begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = pc;
        end
        S_MEM: begin
          mem.mem_req  = 1'b1;
          mem.mem_addr = f;
          if (op == OP_STORE) begin
            mem.mem_we    = 1'b1;
            mem.mem_wdata = INSTR_W'(rd_v);
          end
        end
        S_EXEC, S_HALT: begin
          mem.mem_req = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_val = '0;
    if (state == S_EXEC) begin
      wr_en = 1'b1;
      case (op)
        OP_LI:   wr_val = imm;
        OP_MOV:  wr_val = a;
        OP_ADD:  wr_val = a + b;
        OP_SUB:  wr_val = a - b;
        OP_XOR:  wr_val = a ^ b;
        OP_OR:   wr_val = a | b;
        OP_AND:  wr_val = a & b;
        default: wr_en  = 1'b0;
      endcase
    end else if (state == S_MEM && mem.mem_ack && op == OP_LOAD) begin
      wr_en  = 1'b1;
      wr_val = DATA_W'(mem.mem_rdata);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
    end else if (wr_en) begin
      rf[rd] <= wr_val;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ir <= '0;
    end else if (fetch_done) begin
      ir <= mem.mem_rdata;
    end
  end

`ifdef MCPU_GEN2_BRANCH_EN
  logic take;

  assign take = (state == S_EXEC) &&
                ((op == OP_JMP) ||
                 ((op == OP_BEQZ) && (rd_v == '0)));

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= '0;
    end else if (fetch_done) begin
      pc <= pc + ADDR_W'(1);
    end else if (take) begin
      pc <= f;
    end
  end
`else
  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= '0;
    end else if (fetch_done) begin
      pc <= pc + ADDR_W'(1);
    end
  end
`endif
endmodule

// File: tb/tb_mcpu_gen2.sv
// Self-checking bench for mcpu_gen2: vector table for register ops,
// write scoreboard on the memory bus, hand sequences for wait/reset/halt.
module tb_mcpu_gen2;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        halted;
  logic [7:0]  pc;
  logic [3:0]  dbg_raddr = '0;
  logic [7:0]  dbg_rdata;
  logic        ack = 1'b0;
  logic [15:0] mem [256];

  int total = 0;
  int bad = 0;
  int ack_mode = 0;
  int ack_delay = 0;
  int wcnt = 0;
  int stab_bad = 0;

  logic [7:0]  lat_addr;
  logic        lat_we;
  logic [15:0] lat_wdata;

  typedef struct packed {
    logic [7:0]  addr;
    logic [15:0] data;
  } wr_t;

  wr_t        wq[$];
  logic [7:0] rd_log[$];

  typedef struct {
    logic [3:0] op;
    logic [3:0] rd;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    string      name;
  } vec_t;

`ifdef MCPU_GEN2_BRANCH_EN
  localparam bit BR = 1'b1;
`else
  localparam bit BR = 1'b0;
`endif

  always #5 clk = ~clk;

  mcpu_gen2_if #(.ADDR_W(8), .INSTR_W(16)) bus ();

  assign bus.mem_ack   = ack;
  assign bus.mem_rdata = mem[bus.mem_addr];

  mcpu_gen2 #(.DATA_W(8), .REG_AW(4), .ADDR_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .mem       (bus),
    .halted    (halted),
    .pc        (pc),
    .dbg_raddr (dbg_raddr),
    .dbg_rdata (dbg_rdata)
  );

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", name, act, exp);
    end
  endtask

  // Memory model: ack decided on the falling edge, seen at the next rise.
  always @(negedge clk) begin
    wr_t e;
    if (ack_mode == 1) begin
      ack = 1'b0;
      wcnt = 0;
    end else if (ack_mode == 2) begin
      ack = 1'b1;
      wcnt = 0;
    end else if (!bus.mem_req) begin
      ack = 1'b0;
      wcnt = 0;
    end else begin
      if (wcnt == 0) begin
        lat_addr  = bus.mem_addr;
        lat_we    = bus.mem_we;
        lat_wdata = bus.mem_wdata;
      end else if (bus.mem_addr !== lat_addr || bus.mem_we !== lat_we ||
                   bus.mem_wdata !== lat_wdata) begin
        stab_bad++;
      end
      if (wcnt >= ack_delay) begin
        ack = 1'b1;
        wcnt = 0;
        if (bus.mem_we) begin
          chk("wr_expected", 32'(wq.size() != 0), 32'd1);
          if (wq.size() != 0) begin
            e = wq.pop_front();
            chk("wr_addr", 32'(bus.mem_addr), 32'(e.addr));
            chk("wr_data", 32'(bus.mem_wdata), 32'(e.data));
          end
          mem[bus.mem_addr] = bus.mem_wdata;
        end else begin
          rd_log.push_back(bus.mem_addr);
        end
      end else begin
        ack = 1'b0;
        wcnt++;
      end
    end
  end

  function automatic logic [15:0] enc(input logic [3:0] op,
                                      input logic [3:0] rd,
                                      input logic [7:0] f);
    return {op, rd, f};
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [3:0] rd,
                              input logic [7:0] a, input logic [7:0] b,
                              input logic [7:0] exp, input string name);
    vec_t v;
    v.op = op;
    v.rd = rd;
    v.a = a;
    v.b = b;
    v.exp = exp;
    v.name = name;
    return v;
  endfunction

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) mem[i] = enc(4'd15, 4'd0, 8'd0);
    wq.delete();
    rd_log.delete();
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic run_halt(output int cyc);
    cyc = 0;
    while (!halted && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("halt_reached", 32'(halted), 32'd1);
  endtask

  task automatic rreg(input int r, output logic [7:0] v);
    dbg_raddr = 4'(r);
    #1;
    v = dbg_rdata;
  endtask

  initial begin
    vec_t       vt[12];
    int         cyc;
    int         hb;
    int         rb;
    logic [7:0] v;

    vt[0]  = mk(4'd0,  4'd3, 8'h00, 8'h00, 8'h12, "li");
    vt[1]  = mk(4'd1,  4'd3, 8'h5C, 8'h00, 8'h5C, "mov");
    vt[2]  = mk(4'd2,  4'd3, 8'hF0, 8'h20, 8'h10, "add_wrap");
    vt[3]  = mk(4'd3,  4'd3, 8'h20, 8'hF0, 8'h30, "sub_wrap");
    vt[4]  = mk(4'd3,  4'd3, 8'h05, 8'h05, 8'h00, "sub_zero");
    vt[5]  = mk(4'd4,  4'd3, 8'hA5, 8'hFF, 8'h5A, "xor");
    vt[6]  = mk(4'd5,  4'd3, 8'h0F, 8'h30, 8'h3F, "or");
    vt[7]  = mk(4'd6,  4'd3, 8'hF0, 8'h3C, 8'h30, "and");
    vt[8]  = mk(4'd2,  4'd1, 8'h7F, 8'h01, 8'h80, "add_rd_eq_rs");
    vt[9]  = mk(4'd3,  4'd2, 8'h10, 8'h03, 8'h0D, "sub_rd_eq_rt");
    vt[10] = mk(4'd11, 4'd3, 8'h11, 8'h22, 8'h00, "nop11");
    vt[11] = mk(4'd14, 4'd3, 8'h11, 8'h22, 8'h00, "nop14");

    ack_mode = 0;
    ack_delay = 0;

    for (int i = 0; i < 12; i++) begin
      clear_prog();
      mem[0] = enc(4'd0, 4'd1, vt[i].a);
      mem[1] = enc(4'd0, 4'd2, vt[i].b);
      mem[2] = enc(vt[i].op, vt[i].rd, 8'h12);
      apply_reset();
      run_halt(cyc);
      chk({vt[i].name, "_cyc"}, 32'(cyc), 32'd8);
      rreg(int'(vt[i].rd), v);
      chk(vt[i].name, 32'(v), 32'(vt[i].exp));
    end

    clear_prog();
    mem[0] = enc(4'd0, 4'd3, 8'hA5);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("rst_req", 32'(bus.mem_req), 32'd0);
    chk("rst_halted", 32'(halted), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    @(posedge clk);
    #1;
    chk("rst_req2", 32'(bus.mem_req), 32'd0);
    chk("rst_addr", 32'(bus.mem_addr), 32'd0);
    chk("rst_we", 32'(bus.mem_we), 32'd0);
    chk("rst_wdata", 32'(bus.mem_wdata), 32'd0);
    for (int r = 0; r < 16; r++) begin
      rreg(r, v);
      chk($sformatf("rst_r%0d", r), 32'(v), 32'd0);
    end
    @(posedge clk);
    #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rel_pc", 32'(pc), 32'd1);
    rreg(3, v);
    chk("rel_r3", 32'(v), 32'hA5);

    for (int d = 0; d <= 3; d += 3) begin
      clear_prog();
      mem[0] = enc(4'd0, 4'd1, 8'hF0);
      mem[1] = enc(4'd0, 4'd2, 8'h20);
      mem[2] = enc(4'd2, 4'd4, 8'h12);
      mem[3] = enc(4'd3, 4'd5, 8'h21);
      mem[4] = enc(4'd7, 4'd4, 8'hFA);
      mem[5] = enc(4'd8, 4'd6, 8'hFA);
      wq.push_back('{addr: 8'hFA, data: 16'h0010});
      ack_delay = d;
      stab_bad = 0;
      apply_reset();
      run_halt(cyc);
      chk($sformatf("ldst_cyc_d%0d", d), 32'(cyc), 32'(16 + 9 * d));
      rreg(4, v);
      chk("ldst_r4", 32'(v), 32'h10);
      rreg(5, v);
      chk("ldst_r5", 32'(v), 32'h30);
      rreg(6, v);
      chk("ldst_r6", 32'(v), 32'h10);
      chk("wr_drain", 32'(wq.size()), 32'd0);
      chk("bus_stable", 32'(stab_bad), 32'd0);
    end
    ack_delay = 0;

    clear_prog();
    for (int i = 0; i < 5; i++) mem[i] = enc(4'd11, 4'd0, 8'd0);
    apply_reset();
    run_halt(cyc);
    chk("halt_pc", 32'(pc), 32'd6);
    chk("halt_cyc", 32'(cyc), 32'd12);
    hb = 0;
    rb = 0;
    repeat (20) begin
      @(posedge clk);
      #1;
      if (!halted) hb++;
      if (bus.mem_req) rb++;
    end
    chk("halt_stays", 32'(hb), 32'd0);
    chk("halt_no_req", 32'(rb), 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("halt_rst_pc", 32'(pc), 32'd0);
    chk("halt_rst_flag", 32'(halted), 32'd0);

    clear_prog();
    for (int i = 0; i < 16; i++) mem[i] = enc(4'd11, 4'd0, 8'd0);
    mem[16] = enc(4'd10, 4'd0, 8'h40);
    apply_reset();
    run_halt(cyc);
    chk("beqz_taken_fetch", 32'(rd_log[$]), BR ? 32'h40 : 32'h11);
    chk("beqz_taken_pc", 32'(pc), BR ? 32'h41 : 32'h12);

    clear_prog();
    mem[0] = enc(4'd0, 4'd0, 8'h01);
    for (int i = 1; i < 16; i++) mem[i] = enc(4'd11, 4'd0, 8'd0);
    mem[16] = enc(4'd10, 4'd0, 8'h40);
    apply_reset();
    run_halt(cyc);
    chk("beqz_not_fetch", 32'(rd_log[$]), 32'h11);

    clear_prog();
    mem[0] = enc(4'd9, 4'd0, 8'h30);
    apply_reset();
    run_halt(cyc);
    chk("jmp_fetch", 32'(rd_log[$]), BR ? 32'h30 : 32'h01);
    chk("jmp_cyc", 32'(cyc), 32'd4);

    clear_prog();
    mem[0] = enc(4'd0, 4'd7, 8'h55);
    mem[1] = enc(4'd8, 4'd7, 8'h20);
    mem[8'h20] = 16'h0077;
    apply_reset();
    repeat (3) @(posedge clk);
    #1 ack_mode = 1;
    @(posedge clk);
    #1;
    chk("pend_req", 32'(bus.mem_req), 32'd1);
    chk("pend_addr", 32'(bus.mem_addr), 32'h20);
    chk("pend_we", 32'(bus.mem_we), 32'd0);
    rreg(7, v);
    chk("pend_r7_pre", 32'(v), 32'h55);
    repeat (3) @(posedge clk);
    #1;
    chk("pend_req_held", 32'(bus.mem_req), 32'd1);
    reset = 1'b0;
    #1;
    chk("pend_rst_req", 32'(bus.mem_req), 32'd0);
    ack_mode = 2;
    repeat (2) @(posedge clk);
    #1;
    chk("pend_rst_pc", 32'(pc), 32'd0);
    rreg(7, v);
    chk("pend_rst_r7", 32'(v), 32'd0);
    ack_mode = 1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("late_ack_pc", 32'(pc), 32'd0);
    chk("late_ack_req", 32'(bus.mem_req), 32'd1);
    chk("late_ack_addr", 32'(bus.mem_addr), 32'd0);
    rreg(7, v);
    chk("late_ack_r7", 32'(v), 32'd0);
    chk("no_stray_write", 32'(wq.size()), 32'd0);
    ack_mode = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog");
  end
endmodule
